rv32m_div_unit: RTL
===================

Name: rv32m_div_unit

Overview:
- Iterative divide/remainder unit for the RV32IM EX stage; executes DIV, DIVU, REM and REMU.
- Operands come straight from the register-file read ports (rs1/rs2) via the ID/EX latch.
- The result and destination register index go to the writeback path feeding the register-file write port.
- Restoring radix-2 algorithm, one quotient bit per cycle. Pipeline stalls on BUSY.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock, all state updates on posedge.
- RESET  input  1  reset; synchronous, active-high.
- START  input  1  request; sampled only when BUSY=0.
- FUNCT3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes treated as DIVU.
- OPA  input  XLEN  dividend (rs1 value).
- OPB  input  XLEN  divisor (rs2 value).
- RD_IN  input  5  destination register index.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  single-cycle pulse, RESULT valid.
- RESULT  output  XLEN  quotient or remainder; held until the next DONE.
- RD_OUT  output  5  destination index captured at START; held with RESULT.

Behaviour:
- Reset: RESET is synchronous, active-high, on posedge CLK, and has priority over everything else. On reset: state=IDLE, BUSY=0, DONE=0, RESULT=0, RD_OUT=0, counter=0. Reset aborts any in-flight operation and produces no DONE.
- States: IDLE, CALC, FIX, FINISH.
- IDLE: START=1 latches OPA, OPB, FUNCT3 and RD_IN, then goes to CALC. For signed ops, absolute values and sign flags are captured here. Counter=0.
- CALC: one restoring step per cycle. Shift {rem,quot} left by 1, trial-subtract divisor from rem (XLEN+1-bit compare). If non-negative, commit and set quot LSB=1. After XLEN steps (counter==XLEN-1), go to FIX.
- FIX: apply signs and register the result.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Then go to FINISH.
- FINISH: DONE=1 for exactly this cycle. START=1 here is accepted (back-to-back, next state CALC); otherwise next state is IDLE.
- BUSY=1 in CALC and FIX, 0 in IDLE and FINISH.
- Latency: START at edge N gives DONE high in the cycle after edge N+XLEN+1 (34 cycles for XLEN=32).
- START while BUSY=1 is ignored; no queueing.
- Operand ports are don't-care after the START edge.
- Divide by zero (RISC-V defined):
  - DIV/DIVU result = all ones.
  - REM/REMU result = OPA.
- Signed overflow (OPA=0x80000000, OPB=0xFFFFFFFF, signed ops): DIV result = 0x80000000, REM result = 0.
- All arithmetic is unsigned internally on magnitudes; 0x80000000 magnitude is represented correctly in XLEN bits.

Optional Feature:
- Macro: RV32M_DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed overflow are detected in IDLE at START and bypass CALC (IDLE->FIX). DONE follows 2 cycles after the START edge, with the special result values above.
- Not defined: special cases run the full XLEN iterations with identical results; latency is always XLEN+2.

Decomposition:
- Package rv32m_pkg holds:
  - FUNCT3 constants (F3_DIV, F3_DIVU, F3_REM, F3_REMU).
  - State encoding typedef.
  - XLEN default.
  - Special-value constants: ALL_ONES, INT_MIN.
- One sub-module, div_step: combinational single restoring step taking rem, quot, divisor and producing next rem and quot.
- FSM, counter and sign fix stay in rv32m_div_unit.

Test Plan:
- DIVU OPA=100, OPB=7, RD_IN=5 -> DONE 34 cycles after START, RESULT=14, RD_OUT=5. Repeat as REMU -> RESULT=2.
- DIV OPA=-7 (0xFFFFFFF9), OPB=2 -> RESULT=0xFFFFFFFD (-3). REM on the same operands -> RESULT=0xFFFFFFFF (-1).
- DIV OPA=5, OPB=0 -> 0xFFFFFFFF. REM OPA=5, OPB=0 -> 5. Check latency with and without RV32M_DIV_EARLY_OUT_EN (2 vs 34 cycles).
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- START during BUSY with different operands -> ignored; first result is correct. START asserted in the FINISH cycle -> second op accepted, its DONE 34 cycles later.
- RESET asserted at cycle 10 of CALC -> next cycle BUSY=0, RESULT=0, no DONE. A new op afterwards completes correctly.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared constants and state encoding for the RV32M iterative divider.
package rv32m_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN_DEF-1:0] ALL_ONES = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] INT_MIN  = {1'b1, {(XLEN_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FIX    = 2'd2,
    S_FINISH = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift {rem,quot} left, trial-subtract divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] shifted;
  logic          ge;

  // Compare at XLEN+1 bits; the committed difference always fits in XLEN bits.
  always_comb begin
    shifted   = {rem, quot[XLEN-1]};
    ge        = (shifted >= {1'b0, divisor});
    rem_next  = ge ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    quot_next = {quot[XLEN-2:0], ge};
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit for the EX stage, one quotient bit per cycle.
// Optional RV32M_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module rv32m_div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPA,
  input  logic [XLEN-1:0] OPB,
  input  logic [4:0]      RD_IN,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      RD_OUT
);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem, quot, dvsr, rem_next, quot_next;
  logic             neg_q, neg_r, is_rem, b_zero;
  logic [4:0]       rd_lat;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       rd_out_q;

  logic             accept, is_signed_in, is_rem_in, a_neg, b_neg, b_zero_in;
  logic [XLEN-1:0]  abs_a, abs_b, fix_q, fix_r;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Undefined FUNCT3 codes fall through to unsigned divide.
  assign is_signed_in = (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
  assign is_rem_in    = (FUNCT3 == F3_REM) || (FUNCT3 == F3_REMU);
  assign a_neg        = is_signed_in && OPA[XLEN-1];
  assign b_neg        = is_signed_in && OPB[XLEN-1];
  assign abs_a        = cond_neg(OPA, a_neg);
  assign abs_b        = cond_neg(OPB, b_neg);
  assign b_zero_in    = (OPB == '0);
  assign accept       = START && ((state == S_IDLE) || (state == S_FINISH));

`ifdef RV32M_DIV_EARLY_OUT_EN
  logic ovf_in, special_in;
  assign ovf_in     = is_signed_in && (OPA == XLEN'(INT_MIN)) && (OPB == XLEN'(ALL_ONES));
  assign special_in = b_zero_in || ovf_in;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      S_IDLE, S_FINISH: begin
        DONE = (state == S_FINISH);
        if (START) begin
`ifdef RV32M_DIV_EARLY_OUT_EN
          state_next = special_in ? S_FIX : S_CALC;
`else
          state_next = S_CALC;
`endif
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: begin
        BUSY = 1'b1;
        if (cnt == CNT_W'(XLEN-1)) state_next = S_FIX;
      end
      S_FIX: begin
        BUSY       = 1'b1;
        state_next = S_FINISH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)                 cnt <= '0;
    else if (accept)           cnt <= '0;
    else if (state == S_CALC)  cnt <= cnt + 1'b1;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (dvsr),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Operand capture and iteration; magnitudes only, signs restored in FIX.
  always_ff @(posedge CLK) begin
    if (accept) begin
      dvsr   <= abs_b;
      quot   <= abs_a;
      rem    <= '0;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      is_rem <= is_rem_in;
      b_zero <= b_zero_in;
      rd_lat <= RD_IN;
`ifdef RV32M_DIV_EARLY_OUT_EN
      if (b_zero_in) rem <= abs_a;
      else if (ovf_in) quot <= XLEN'(INT_MIN);
`endif
    end else if (state == S_CALC) begin
      rem  <= rem_next;
      quot <= quot_next;
    end
  end

  // Divide-by-zero quotient is all ones regardless of operand signs.
  assign fix_q = b_zero ? XLEN'(ALL_ONES) : cond_neg(quot, neg_q);
  assign fix_r = cond_neg(rem, neg_r);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q <= '0;
      rd_out_q <= '0;
    end else if (state == S_FIX) begin
      result_q <= is_rem ? fix_r : fix_q;
      rd_out_q <= rd_lat;
    end
  end

  assign RESULT = result_q;
  assign RD_OUT = rd_out_q;

endmodule
